bsh_arb: RTL and testbench
==========================

// Module: bsh_arb
// PURPOSE
//   Round-robin arbiter/scheduler sharing one 32-bit rotate unit (bsh_32 instance) among NREQ requesters.
//   Each requester offers {data, dir, sh} over valid/ready; the winner is rotated and the result is held in a
//   one-entry output register, tagged with the requester id. Sits between client blocks and the single shifter.
// PARAMETERS
//   NREQ  4  number of requesters (2..8)
//   ID_W  2  width of rsp_id; must satisfy 2**ID_W >= NREQ
// PORTS
//   clk        in   1        single clock, all state updates on rising edge
//   rst        in   1        synchronous, active-high reset
//   req_valid  in   NREQ     requester i offers an operation
//   req_ready  out  NREQ     requester i's operation is accepted this cycle
//   req_data   in   32*NREQ  operand of requester i at [32*i+31:32*i]
//   req_dir    in   NREQ     0 = rotate left, 1 = rotate right
//   req_sh     in   5*NREQ   rotate amount of requester i at [5*i+4:5*i]
//   rsp_valid  out  1        output register holds a result
//   rsp_ready  in   1        downstream consumes the result
//   rsp_data   out  32       rotated word
//   rsp_id     out  ID_W     index of the requester that produced rsp_data
// BEHAVIOUR
//   - Reset (sync, rst=1 at clk edge): rsp_valid=0, rsp_data=0, rsp_id=0, rr pointer=0; req_ready=0 while rst=1.
//   - Output register has two states: EMPTY (rsp_valid=0) and FULL (rsp_valid=1).
//   - can_accept = !rsp_valid | rsp_ready (combinational); accept = can_accept & |req_valid.
//   - Grant: first i with req_valid[i]=1 scanning ptr, ptr+1, ... , NREQ-1, 0, ... (wrap-around).
//   - req_ready is one-hot or zero: req_ready[g]=accept for the granted g only. req_ready never depends on
//     req_valid of its own bit beyond the grant decision; no combinational path from rsp_ready to rsp_data.
//   - On accept: rsp_data <= rotate(req_data[g], req_dir[g], req_sh[g]); rsp_id <= g; rsp_valid <= 1;
//     ptr <= (g == NREQ-1) ? 0 : g+1. Latency: result visible the cycle after acceptance.
//   - rsp_valid & rsp_ready & no accept: rsp_valid <= 0 (FULL->EMPTY); rsp_data/rsp_id keep last value.
//   - rsp_valid & rsp_ready & accept (simultaneous): register reloaded same edge, rsp_valid stays 1;
//     sustained throughput one operation per cycle.
//   - FULL & !rsp_ready: no grant, all req_ready=0, rsp_data/rsp_id/ptr held stable.
//   - No requests: ptr unchanged.
//   - Rotate semantics: left = {x[31-s:0], x[31:32-s]}; right = {x[s-1:0], x[31:s]}; s=0 passes x unchanged;
//     s=16 identical for both directions. All arithmetic mod 32 on the 5-bit amount.
//   - Reset mid-operation: any held result dropped (rsp_valid=0), pending requests are not accepted in the
//     reset cycle; the pointer restarts at requester 0.
// CONFIGURATION
//   BSH_ARB_PRIO_EN defined: requester 0 has strict priority; when req_valid[0]=1 it is always granted;
//     otherwise round-robin among 1..NREQ-1 with ptr skipping 0. Undefined: pure round-robin over all NREQ
//     requesters, starvation-free (each valid requester served within NREQ accepts).
// TESTING
//   1. Reset: hold rst 2 cycles with all req_valid=1 -> rsp_valid=0, rsp_data=0, rsp_id=0, req_ready=0.
//   2. Single op: req0 data=32'h8000_0001, dir=0, sh=1 -> next cycle rsp_valid=1, rsp_data=32'h0000_0003, rsp_id=0.
//   3. Right rotate: req2 data=32'h1234_5678, dir=1, sh=8 -> rsp_data=32'h7812_3456, rsp_id=2.
//   4. Round-robin: all 4 valid continuously, rsp_ready=1 -> rsp_id sequence 0,1,2,3,0,... one per cycle.
//   5. Backpressure: rsp_ready=0 for 3 cycles while FULL -> req_ready=0, rsp_data/rsp_id stable; release ->
//      held result consumed and next grant loaded on same edge.
//   6. BSH_ARB_PRIO_EN: req0 and req1 continuously valid -> every grant to 0; drop req0 -> req1 granted
//      next cycle.

Source files
------------

// File: rtl/bsh_arb.sv
// Round-robin arbiter sharing one 32-bit rotate unit among NREQ requesters, with a one-entry result register.
// Optional macro BSH_ARB_PRIO_EN: requester 0 gets strict priority, round-robin among the rest.
module bsh_arb #(
  parameter int NREQ = 4,
  parameter int ID_W = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [32*NREQ-1:0]   req_data,
  input  logic [NREQ-1:0]      req_dir,
  input  logic [5*NREQ-1:0]    req_sh,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [31:0]          rsp_data,
  output logic [ID_W-1:0]      rsp_id
);

  // Handshake: a transfer happens on a rising edge where valid and ready are both high;
  // valid, once raised, holds its payload until that edge, and ready never waits on the
  // same side's valid except through the grant decision.

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t          state, state_nxt;
  logic [ID_W-1:0] ptr;
  logic [ID_W-1:0] grant;
  logic            found;
  logic            can_accept;
  logic            accept;
  logic [NREQ-1:0] elig;
  logic [31:0]     sel_data;
  logic            sel_dir;
  logic [4:0]      sel_sh;
  logic [31:0]     rot_data;
  int              idx;

  // Grant search: first eligible requester at or after ptr, wrapping.
  always_comb begin
    found = 1'b0;
    grant = '0;
    idx   = 0;
    elig  = req_valid;
`ifdef BSH_ARB_PRIO_EN
    elig[0] = 1'b0;
    if (req_valid[0]) found = 1'b1;
`endif
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      for (int i = 0; i < NREQ; i++) begin
        if (!found && idx == i && elig[i]) begin
          found = 1'b1;
          grant = ID_W'(i);
        end
      end
    end
  end

  assign can_accept = (state == EMPTY) || rsp_ready;
  assign accept     = can_accept && found && !rst;

  always_comb begin
    sel_data  = '0;
    sel_dir   = 1'b0;
    sel_sh    = '0;
    req_ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant == ID_W'(i)) begin
        sel_data     = req_data[32*i +: 32];
        sel_dir      = req_dir[i];
        sel_sh       = req_sh[5*i +: 5];
        req_ready[i] = accept;
      end
    end
  end

  // Shift by (32 - s) with a 6-bit amount so s=0 yields a zero fill term.
  always_comb begin
    if (sel_dir)
      rot_data = (sel_data >> sel_sh) | (sel_data << (6'd32 - {1'b0, sel_sh}));
    else
      rot_data = (sel_data << sel_sh) | (sel_data >> (6'd32 - {1'b0, sel_sh}));
  end

  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY:   if (accept) state_nxt = FULL;
      FULL:    if (rsp_ready && !accept) state_nxt = EMPTY;
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= EMPTY;
      rsp_data <= '0;
      rsp_id   <= '0;
      ptr      <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        rsp_data <= rot_data;
        rsp_id   <= grant;
        ptr      <= (grant == ID_W'(NREQ - 1)) ? '0 : grant + 1'b1;
      end
    end
  end

  assign rsp_valid = (state == FULL);

endmodule

// File: tb/tb_bsh_arb.sv
// Directed plus random stimulus for bsh_arb, checked against a distance-based round-robin model.
module tb_bsh_arb;

  localparam int NREQ = 4;
  localparam int ID_W = 2;
  localparam int W    = 32 + ID_W;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [32*NREQ-1:0]   req_data;
  logic [NREQ-1:0]      req_dir;
  logic [5*NREQ-1:0]    req_sh;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [31:0]          rsp_data;
  logic [ID_W-1:0]      rsp_id;

  int n_checks = 0;
  int n_errors = 0;

  // Reference state: pending result queue, last shown result, last granted requester.
  logic [W-1:0]    exp_q[$];
  logic [31:0]     m_data;
  logic [ID_W-1:0] m_id;
  int              m_last;

  bsh_arb #(.NREQ(NREQ), .ID_W(ID_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_data(req_data), .req_dir(req_dir), .req_sh(req_sh),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_id(rsp_id)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_rot(input logic [31:0] x, input logic dir, input int s);
    logic [31:0] r;
    for (int b = 0; b < 32; b++) begin
      if (dir) r[(b - s + 32) % 32] = x[b];
      else     r[(b + s) % 32]      = x[b];
    end
    return r;
  endfunction

  function automatic int model_grant();
    int best  = -1;
    int bestd = NREQ;
    int pref  = (m_last + 1) % NREQ;
`ifdef BSH_ARB_PRIO_EN
    if (req_valid[0]) return 0;
`endif
    for (int i = 0; i < NREQ; i++) begin
      int d = (i - pref + NREQ) % NREQ;
`ifdef BSH_ARB_PRIO_EN
      if (i == 0) continue;
`endif
      if (req_valid[i] && d < bestd) begin
        bestd = d;
        best  = i;
      end
    end
    return best;
  endfunction

  task automatic set_req(input int i, input logic [31:0] d, input logic dir, input int sh);
    req_valid[i]        = 1'b1;
    req_data[32*i +: 32] = d;
    req_dir[i]          = dir;
    req_sh[5*i +: 5]    = sh[4:0];
  endtask

  task automatic clear_reqs();
    req_valid = '0;
    req_data  = '0;
    req_dir   = '0;
    req_sh    = '0;
  endtask

  task automatic rand_reqs();
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i]         = ($urandom_range(0, 99) < 60);
      req_data[32*i +: 32] = $urandom;
      req_dir[i]           = $urandom_range(0, 1);
      req_sh[5*i +: 5]     = 5'($urandom_range(0, 31));
    end
  endtask

  // One clock: check ready against the model, advance model on the edge, check the result register.
  task automatic step(input logic rdy);
    int g;
    logic acc;
    logic [NREQ-1:0] exp_ready;
    rsp_ready = rdy;
    #1;
    g   = model_grant();
    acc = (exp_q.size() == 0 || rdy) && g >= 0 && !rst;
    exp_ready = '0;
    if (acc) exp_ready[g] = 1'b1;
    chk("req_ready", 32'(req_ready), 32'(exp_ready));
    @(posedge clk);
    if (rst) begin
      exp_q.delete();
      m_data = '0;
      m_id   = '0;
      m_last = NREQ - 1;
    end else begin
      if (exp_q.size() != 0 && rdy) void'(exp_q.pop_front());
      if (acc) begin
        m_data = ref_rot(req_data[32*g +: 32], req_dir[g], int'(req_sh[5*g +: 5]));
        m_id   = ID_W'(g);
        m_last = g;
        exp_q.push_back({m_id, m_data});
      end
    end
    #1;
    chk("rsp_valid", 32'(rsp_valid), 32'(exp_q.size() != 0));
    chk("rsp_data", rsp_data, m_data);
    chk("rsp_id", 32'(rsp_id), 32'(m_id));
  endtask

  initial begin
    rst       = 1'b1;
    rsp_ready = 1'b0;
    clear_reqs();
    exp_q.delete();
    m_data = '0;
    m_id   = '0;
    m_last = NREQ - 1;

    // Reset with every requester asking.
    for (int i = 0; i < NREQ; i++) set_req(i, $urandom, 1'b0, 3);
    step(1'b1);
    step(1'b1);
    rst = 1'b0;
    clear_reqs();
    step(1'b1);

    // Single left rotate from requester 0.
    set_req(0, 32'h8000_0001, 1'b0, 1);
    step(1'b1);
    chk("single_data", rsp_data, 32'h0000_0003);
    chk("single_id", 32'(rsp_id), 32'd0);
    clear_reqs();
    step(1'b1);

    // Right rotate from requester 2.
    set_req(2, 32'h1234_5678, 1'b1, 8);
    step(1'b1);
    chk("right_data", rsp_data, 32'h7812_3456);
    chk("right_id", 32'(rsp_id), 32'd2);
    clear_reqs();
    step(1'b1);

    // Amount boundaries: 0 and 16 in both directions, 31 left.
    set_req(1, 32'hdead_beef, 1'b1, 0);
    step(1'b1);
    chk("sh0_data", rsp_data, 32'hdead_beef);
    clear_reqs();
    set_req(3, 32'hcafe_f00d, 1'b0, 16);
    step(1'b1);
    chk("sh16_left", rsp_data, 32'hf00d_cafe);
    clear_reqs();
    set_req(0, 32'hcafe_f00d, 1'b1, 16);
    step(1'b1);
    chk("sh16_right", rsp_data, 32'hf00d_cafe);
    clear_reqs();
    set_req(2, 32'h0000_0001, 1'b0, 31);
    step(1'b1);
    chk("sh31_left", rsp_data, 32'h8000_0000);
    clear_reqs();
    step(1'b1);

    // Round-robin from a fresh pointer with all requesters valid.
    rst = 1'b1;
    step(1'b1);
    rst = 1'b0;
    for (int i = 0; i < NREQ; i++) set_req(i, 32'h0000_0100 << i, 1'b0, i);
    for (int k = 0; k < 8; k++) begin
      step(1'b1);
`ifndef BSH_ARB_PRIO_EN
      chk("rr_seq", 32'(rsp_id), 32'(k % NREQ));
`endif
    end

    // Backpressure while full, then release.
    for (int k = 0; k < 3; k++) step(1'b0);
    step(1'b1);
    step(1'b1);

    // Reset while holding a result.
    step(1'b0);
    rst = 1'b1;
    step(1'b0);
    chk("midrst_valid", 32'(rsp_valid), 32'd0);
    rst = 1'b0;
    clear_reqs();
    step(1'b1);

    // Random traffic with random downstream stalls.
    for (int k = 0; k < 300; k++) begin
      rand_reqs();
      step(($urandom_range(0, 99) < 70) ? 1'b1 : 1'b0);
    end
    clear_reqs();
    step(1'b1);
    step(1'b1);

`ifdef BSH_ARB_PRIO_EN
    // Requester 0 keeps winning; dropping it hands the next grant to requester 1.
    rst = 1'b1;
    step(1'b1);
    rst = 1'b0;
    set_req(0, 32'h1, 1'b0, 1);
    set_req(1, 32'h2, 1'b0, 1);
    for (int k = 0; k < 4; k++) begin
      step(1'b1);
      chk("prio_id0", 32'(rsp_id), 32'd0);
    end
    req_valid[0] = 1'b0;
    step(1'b1);
    chk("prio_id1", 32'(rsp_id), 32'd1);
    clear_reqs();
    step(1'b1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
